// File: rtl/jtag_master_if.sv
// jtag_master_if: command/response handshake bundle between a command source
// (master modport) and the jtag_master driver (slave modport).
interface jtag_master_if #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG driver. Turns one-cycle scan commands into
// TCK/TMS/TDI waveforms, captures TDO, and always parks the TAP in
// run_test_idle. A 6-TCK TAP reset plays automatically after rst.
// Optional build macro: JTAG_MASTER_LEN_CHECK_EN -- SCAN_* commands with
// cmd_len of 0 or above MAX_LEN are answered at once with rsp_err=1 and no
// TCK activity. Without it rsp_err is tied 0.
module jtag_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic         clk,
  input  logic         rst,
  jtag_master_if.slave bus,
  output logic         tck,
  output logic         tms,
  output logic         tdi,
  input  logic         tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // One extra bit covers both MAX_LEN+6 scan TCKs and the longest IDLE count.
  localparam int CNT_W = LEN_W + 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    OP_RESET   = 2'b00,
    OP_SCAN_IR = 2'b01,
    OP_SCAN_DR = 2'b10,
    OP_IDLE    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    BOOT_RST,
    IDLE,
    SHIFT_SEQ,
    RESP
  } state_e;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   idx_q;
  logic [CNT_W-1:0]   total_q;
  logic [MAX_LEN-1:0] data_q;
  logic [DIV_W-1:0]   div_q;
  logic               tck_q, tms_q, tdi_q;
  logic [MAX_LEN-1:0] rsp_data_q;

  op_e                cmd_op_w;
  logic [CNT_W-1:0]   cmd_len_w;
  logic               seq_on, div_end, rise, fall, last;
  logic               accept, len_bad, imm_rsp;

  // TCKs spent walking from run_test_idle into the shift state.
  function automatic logic [CNT_W-1:0] pre_len(op_e op);
    case (op)
      OP_SCAN_IR: pre_len = CNT_W'(4);
      OP_SCAN_DR: pre_len = CNT_W'(3);
      default:    pre_len = '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] total_tcks(op_e op, logic [CNT_W-1:0] n);
    case (op)
      OP_RESET:   total_tcks = CNT_W'(6);
      OP_SCAN_IR: total_tcks = n + CNT_W'(6);
      OP_SCAN_DR: total_tcks = n + CNT_W'(5);
      default:    total_tcks = n;
    endcase
  endfunction

  function automatic logic is_scan(op_e op);
    is_scan = (op == OP_SCAN_IR) || (op == OP_SCAN_DR);
  endfunction

  function automatic logic in_shift(op_e op, logic [CNT_W-1:0] idx, logic [CNT_W-1:0] n);
    in_shift = is_scan(op) && (idx >= pre_len(op)) && (idx < pre_len(op) + n);
  endfunction

  // TMS level for TCK rise number idx of a command, walked from run_test_idle.
  function automatic logic tms_at(op_e op, logic [CNT_W-1:0] idx, logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] pre;
    pre = pre_len(op);
    case (op)
      OP_RESET: tms_at = (idx < CNT_W'(5));
      OP_IDLE:  tms_at = 1'b0;
      default: begin
        if (idx < pre)
          tms_at = (idx == '0) || ((op == OP_SCAN_IR) && (idx == CNT_W'(1)));
        else
          tms_at = (idx == pre + n - CNT_W'(1)) || (idx == pre + n);
      end
    endcase
  endfunction

  function automatic logic tdi_at(op_e op, logic [CNT_W-1:0] idx, logic [CNT_W-1:0] n,
                                  logic [MAX_LEN-1:0] d);
    if (in_shift(op, idx, n))
      tdi_at = d[IDX_W'(idx - pre_len(op))];
    else
      tdi_at = 1'b0;
  endfunction

  assign cmd_op_w  = op_e'(bus.cmd_op);
  assign cmd_len_w = CNT_W'(bus.cmd_len);

`ifdef JTAG_MASTER_LEN_CHECK_EN
  assign len_bad = is_scan(cmd_op_w) &&
                   ((cmd_len_w == '0) || (cmd_len_w > CNT_W'(MAX_LEN)));
`else
  assign len_bad = 1'b0;
`endif

  assign imm_rsp = len_bad || ((cmd_op_w == OP_IDLE) && (cmd_len_w == '0));

  assign seq_on  = (state_q == BOOT_RST) || (state_q == SHIFT_SEQ);
  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign rise    = seq_on && !tck_q && div_end;
  assign fall    = seq_on &&  tck_q && div_end;
  assign last    = (idx_q == total_q - CNT_W'(1));

  // Next state and command acceptance.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      BOOT_RST:  if (fall && last) state_d = IDLE;
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = imm_rsp ? RESP : SHIFT_SEQ;
        end
      end
      SHIFT_SEQ: if (fall && last) state_d = RESP;
      RESP:      if (bus.rsp_ready) state_d = IDLE;
      default:   state_d = BOOT_RST;
    endcase
  end

  // State register; reset always restarts with the TAP reset sequence.
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT_RST;
    else     state_q <= state_d;
  end

  // TCK divider, TMS/TDI sequencer and TDO capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      div_q      <= '0;
      idx_q      <= '0;
      op_q       <= OP_RESET;
      total_q    <= CNT_W'(6);
      rsp_data_q <= '0;
    end else if (accept) begin
      op_q       <= cmd_op_w;
      len_q      <= cmd_len_w;
      data_q     <= bus.cmd_data;
      total_q    <= total_tcks(cmd_op_w, cmd_len_w);
      idx_q      <= '0;
      div_q      <= '0;
      tck_q      <= 1'b0;
      // Immediate responses must not disturb the pins.
      tms_q      <= imm_rsp ? tms_q : tms_at(cmd_op_w, '0, cmd_len_w);
      tdi_q      <= imm_rsp ? 1'b0  : tdi_at(cmd_op_w, '0, cmd_len_w, bus.cmd_data);
      rsp_data_q <= '0;
    end else if (seq_on) begin
      if (div_end) begin
        div_q <= '0;
        tck_q <= ~tck_q;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      // TDO has been stable since the previous falling edge.
      if (rise && (state_q == SHIFT_SEQ) && in_shift(op_q, idx_q, len_q))
        rsp_data_q[IDX_W'(idx_q - pre_len(op_q))] <= tdo;
      if (fall) begin
        if (last) begin
          tdi_q <= 1'b0;
        end else begin
          idx_q <= idx_q + CNT_W'(1);
          tms_q <= tms_at(op_q, idx_q + CNT_W'(1), len_q);
          tdi_q <= tdi_at(op_q, idx_q + CNT_W'(1), len_q, data_q);
        end
      end
    end
  end

`ifdef JTAG_MASTER_LEN_CHECK_EN
  logic rsp_err_q;

  // Error flag latched with each accepted command.
  always_ff @(posedge clk) begin
    if (rst)         rsp_err_q <= 1'b0;
    else if (accept) rsp_err_q <= len_bad;
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign tck           = tck_q;
  assign tms           = tms_q;
  assign tdi           = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: drives jtag_master against a behavioural RISC-V DTM TAP
// (IDCODE / DTMCS / DMI / BYPASS) kept in this file.
module tb_jtag_master;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int DMI_LEN = 41;
  localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
  localparam logic [31:0] DTMCS_VAL  = 32'h0000_7071;

  logic clk = 1'b0;
  logic rst;
  logic tck, tms, tdi, tdo;

  jtag_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_master #(.CLK_DIV(4), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tck (tck),
    .tms (tms),
    .tdi (tdi),
    .tdo (tdo)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural TAP target ----------------
  typedef enum int {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_e;

  tap_e        ts = TLR;
  logic [4:0]  ir = 5'h01;
  logic [4:0]  ir_sh = 5'h00;
  logic [63:0] dr = 64'h0;
  logic [DMI_LEN-1:0] dmi_reg = '0;
  int          dmi_upd = 0;
  logic        tdo_r = 1'b0;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  function automatic int dr_len(logic [4:0] i);
    case (i)
      5'h01:   return 32;
      5'h10:   return 32;
      5'h11:   return DMI_LEN;
      default: return 1;
    endcase
  endfunction

  // TAP register actions on each TCK rise.
  always @(posedge tck) begin
    case (ts)
      TLR:    ir <= 5'h01;
      CAP_DR: begin
        case (ir)
          5'h01:   dr <= {32'h0, IDCODE_VAL};
          5'h10:   dr <= {32'h0, DTMCS_VAL};
          5'h11:   dr <= {23'h0, dmi_reg};
          default: dr <= 64'h0;
        endcase
      end
      SH_DR:  dr <= (dr >> 1) | ({63'h0, tdi} << (dr_len(ir) - 1));
      UPD_DR: if (ir == 5'h11) begin
        dmi_reg <= dr[DMI_LEN-1:0];
        dmi_upd <= dmi_upd + 1;
      end
      CAP_IR: ir_sh <= 5'b00001;
      SH_IR:  ir_sh <= {tdi, ir_sh[4:1]};
      UPD_IR: ir <= ir_sh;
      default: ;
    endcase
    ts <= tap_next(ts, tms);
  end

  // TAP drives TDO on the falling edge.
  always @(negedge tck) tdo_r <= (ts == SH_DR) ? dr[0] : (ts == SH_IR) ? ir_sh[0] : 1'b0;
  assign tdo = tdo_r;

  // TMS seen at every TCK rise.
  bit tq[$];
  always @(posedge tck) tq.push_back(tms);

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] exp_tms(input logic [1:0] op, input int n);
    bit q[$];
    logic [127:0] v;
    case (op)
      2'b00: begin repeat (5) q.push_back(1'b1); q.push_back(1'b0); end
      2'b01: begin
        q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b0);
        repeat (n - 1) q.push_back(1'b0);
        q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0);
      end
      2'b10: begin
        q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b0);
        repeat (n - 1) q.push_back(1'b0);
        q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0);
      end
      default: repeat (n) q.push_back(1'b0);
    endcase
    v = '0;
    foreach (q[k]) v[k] = q[k];
    return v;
  endfunction

  function automatic int exp_count(input logic [1:0] op, input int n);
    case (op)
      2'b00:   return 6;
      2'b01:   return n + 6;
      2'b10:   return n + 5;
      default: return n;
    endcase
  endfunction

  function automatic logic [127:0] obs_tms();
    logic [127:0] v;
    v = '0;
    foreach (tq[k]) if (k < 128) v[k] = tq[k];
    return v;
  endfunction

  function automatic logic [63:0] mask(input int n);
    return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 400) begin @(negedge clk); t++; end
    check(tag, 128'(bus.cmd_ready), 128'(1'b1));
  endtask

  logic [63:0]  r_data;
  logic         r_err;
  int           r_rises;
  logic [127:0] r_tms;
  int           r_lat;

  task automatic run_cmd(input logic [1:0] op, input int len, input logic [63:0] data);
    int t;
    @(negedge clk);
    wait_ready("cmd_ready");
    tq.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    t = 0;
    while (!bus.rsp_valid && t < 800) begin @(negedge clk); t++; end
    if (!bus.rsp_valid) check("rsp_timeout", 128'(bus.rsp_valid), 128'(1'b1));
    r_lat   = t;
    r_data  = bus.rsp_data;
    r_err   = bus.rsp_err;
    r_rises = tq.size();
    r_tms   = obs_tms();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic scan_check(input string tag, input logic [1:0] op, input int len,
                            input logic [63:0] data, input logic [63:0] exp_data);
    run_cmd(op, len, data);
    check({tag, "_data"},  128'(r_data), 128'(exp_data));
    check({tag, "_err"},   128'(r_err), 128'(1'b0));
    check({tag, "_tcks"},  128'(r_rises), 128'(exp_count(op, len)));
    check({tag, "_tms"},   r_tms, exp_tms(op, len));
    check({tag, "_idle"},  128'(ts == RTI), 128'(1'b1));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]        d, prev_dmi, held;
    logic [DMI_LEN-1:0] x;
    int                 n, base_upd, base_rises;
    bit                 stable;

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_len = '0;
    bus.cmd_data = '0;    bus.rsp_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_pins", 128'({tck, tms, tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err}),
          128'(6'b010000));
    check("reset_rsp_data", 128'(bus.rsp_data), 128'(0));

    // Boot sequence after reset release.
    tq.delete();
    rst = 1'b0;
    wait_ready("boot_ready");
    check("boot_tcks", 128'(tq.size()), 128'(6));
    check("boot_tms", obs_tms(), exp_tms(2'b00, 0));
    check("boot_idle", 128'(ts == RTI), 128'(1'b1));

    scan_check("idcode", 2'b10, 32, {$urandom, $urandom}, {32'h0, IDCODE_VAL});
    scan_check("ir_dtmcs", 2'b01, 5, 64'h10, 64'h1);
    scan_check("dtmcs", 2'b10, 32, 64'h0, {32'h0, DTMCS_VAL});
    scan_check("ir_dmi", 2'b01, 5, 64'h11, 64'h1);

    // DMI writes: capture returns the previously written value.
    prev_dmi = 64'h0;
    for (int k = 0; k < 2; k++) begin
      x = {$urandom, $urandom};
      base_upd = dmi_upd;
      scan_check("dmi", 2'b10, DMI_LEN, 64'(x), prev_dmi);
      check("dmi_pulse", 128'(dmi_upd - base_upd), 128'(1));
      check("dmi_value", 128'(dmi_reg), 128'(x));
      prev_dmi = 64'(x);
    end

    // BYPASS: output is input delayed by one bit, leading 0.
    scan_check("ir_bypass", 2'b01, 5, 64'h1F, 64'h1);
    for (int k = 0; k < 4; k++) begin
      n = (k == 3) ? MAX_LEN : int'($urandom_range(1, 63));
      d = {$urandom, $urandom};
      scan_check("bypass", 2'b10, n, d, (d << 1) & mask(n));
    end

    // IDLE clocks and zero-length IDLE.
    for (int k = 0; k < 2; k++) begin
      n = int'($urandom_range(1, 20));
      scan_check("idle", 2'b11, n, {$urandom, $urandom}, 64'h0);
    end
    run_cmd(2'b11, 0, 64'hFFFF);
    check("idle0_tcks", 128'(r_rises), 128'(0));
    check("idle0_lat", 128'(r_lat), 128'(0));
    check("idle0_data", 128'(r_data), 128'(0));

    // RESET command restores IDCODE in IR.
    scan_check("reset_cmd", 2'b00, 0, 64'hFFFF, 64'h0);
    scan_check("idcode2", 2'b10, 32, 64'h0, {32'h0, IDCODE_VAL});

    // Back-pressure: response held while rsp_ready stays low, new command ignored.
    @(negedge clk);
    wait_ready("bp_ready");
    tq.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_len = LEN_W'(32); bus.cmd_data = '0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int t = 0; t < 800 && !bus.rsp_valid; t++) @(negedge clk);
    held = bus.rsp_data;
    base_rises = tq.size();
    check("bp_data", 128'(held), 128'({32'h0, IDCODE_VAL}));
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_len = LEN_W'(5);
    stable = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_data === held &&
            bus.cmd_ready === 1'b0 && tck === 1'b0)) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'(1'b1));
    check("bp_no_tck", 128'(tq.size() - base_rises), 128'(0));
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_release", 128'({bus.cmd_ready, bus.rsp_valid}), 128'(2'b10));

    // Reset in the middle of a DR scan (during bit 10).
    tq.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_len = LEN_W'(32);
    bus.cmd_data = 64'hFFFF_FFFF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int t = 0; t < 400 && tq.size() < 14; t++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pins", 128'({tck, tms, tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err}),
          128'(6'b010000));
    check("abort_rsp_data", 128'(bus.rsp_data), 128'(0));
    repeat (2) @(negedge clk);
    tq.delete();
    rst = 1'b0;
    wait_ready("reboot_ready");
    check("reboot_tcks", 128'(tq.size()), 128'(6));
    check("reboot_tms", obs_tms(), exp_tms(2'b00, 0));
    scan_check("idcode3", 2'b10, 32, 64'h0, {32'h0, IDCODE_VAL});

`ifdef JTAG_MASTER_LEN_CHECK_EN
    run_cmd(2'b10, 0, 64'h5);
    check("len0_tcks", 128'(r_rises), 128'(0));
    check("len0_lat", 128'(r_lat), 128'(0));
    check("len0_err", 128'(r_err), 128'(1'b1));
    check("len0_data", 128'(r_data), 128'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
